// File: rtl/inst_mem_loader.sv
// inst_mem_loader: assembles a byte stream into 32-bit big-endian words and
// writes them to the instruction memory, either into the kernel region
// (target_os=1) or the program region (target_os=0).
// Optional feature: define LOADER_CHECKSUM_EN to append a 4-byte checksum
// phase that compares the 32-bit modular sum of all written words against
// a trailing big-endian checksum word.
module inst_mem_loader (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        target_os,
    input  logic [31:0] base_address,
    input  logic [11:0] word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        byte_ready,
    output logic        gravar_D,
    output logic        write_os,
    output logic [31:0] write_address,
    output logic [31:0] data_write,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // Highest legal value of base_address + word_count (one past the last word).
    localparam logic [32:0] ADDR_LIMIT = 33'd2049;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        CHECK = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        os_q, os_d;
    logic [31:0] base_q, base_d;
    logic [11:0] count_q, count_d;
    logic [11:0] index_q, index_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] word_buf_q, word_buf_d;
    logic        wr_os_q, wr_os_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    logic        byte_fire;
    logic [31:0] assembled;
    logic        last_word;
    logic        range_bad;

    // Handshake, word assembly and end-of-load / range decisions.
    always_comb begin
        byte_fire = byte_ready && byte_valid;
        assembled = {word_buf_q, byte_in};
        last_word = ({1'b0, index_q} + 13'd1) >= {1'b0, count_q};
        range_bad = ({1'b0, base_address} + {21'b0, word_count}) > ADDR_LIMIT;
    end

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_d    = state_q;
        os_d       = os_q;
        base_d     = base_q;
        count_d    = count_q;
        index_d    = index_q;
        byte_cnt_d = byte_cnt_q;
        word_buf_d = word_buf_q;
        wr_os_d    = wr_os_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    os_d       = target_os;
                    base_d     = base_address;
                    count_d    = word_count;
                    index_d    = 12'd0;
                    byte_cnt_d = 2'd0;
                    error_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = 32'd0;
`endif
                    if (range_bad) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else if (word_count != 12'd0) begin
                        state_d = RECV;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end
                end
            end

            RECV: begin
                if (byte_fire) begin
                    word_buf_d = {word_buf_q[15:0], byte_in};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_os_d   = os_q;
                        wr_addr_d = base_q + {20'b0, index_q};
                        wr_data_d = assembled;
                        state_d   = WRITE;
                    end
                end
            end

            WRITE: begin
                index_d = index_q + 12'd1;
`ifdef LOADER_CHECKSUM_EN
                sum_d   = sum_q + wr_data_q;
`endif
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = RECV;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (byte_fire) begin
                    word_buf_d = {word_buf_q[15:0], byte_in};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (assembled != sum_q) begin
                            error_d = 1'b1;
                        end
                        state_d = DONE;
                    end
                end
            end
`endif

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status and write-port outputs decoded from the current state.
    always_comb begin
        byte_ready    = (state_q == RECV);
`ifdef LOADER_CHECKSUM_EN
        byte_ready    = byte_ready || (state_q == CHECK);
`endif
        gravar_D      = (state_q == WRITE);
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
        write_os      = wr_os_q;
        write_address = wr_addr_q;
        data_write    = wr_data_q;
        error         = error_q;
    end

    // State and datapath registers with synchronous reset back to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            os_q       <= 1'b0;
            base_q     <= 32'd0;
            count_q    <= 12'd0;
            index_q    <= 12'd0;
            byte_cnt_q <= 2'd0;
            word_buf_q <= 24'd0;
            wr_os_q    <= 1'b0;
            wr_addr_q  <= 32'd0;
            wr_data_q  <= 32'd0;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            os_q       <= os_d;
            base_q     <= base_d;
            count_q    <= count_d;
            index_q    <= index_d;
            byte_cnt_q <= byte_cnt_d;
            word_buf_q <= word_buf_d;
            wr_os_q    <= wr_os_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: table-driven, hand-written and randomized loads checked
// against a word-level model (bytes -> big-endian words at base+i).
module tb_inst_mem_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic        target_os;
    logic [31:0] base_address;
    logic [11:0] word_count;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        byte_ready;
    logic        gravar_D;
    logic        write_os;
    logic [31:0] write_address;
    logic [31:0] data_write;
    logic        busy;
    logic        done;
    logic        error;

    int tests_run;
    int tests_failed;

    logic [64:0] wr_log[$];
    int          done_pulses;
    int          ready_in_write;
    logic [7:0]  byte_q[$];

    typedef struct {
        bit          os;
        logic [31:0] base;
        logic [11:0] count;
        int          gap;
        bit          mid_start;
        bit          csum_bad;
        bit          exp_range_err;
    } vec_t;

    vec_t vecs[10];

    inst_mem_loader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .target_os    (target_os),
        .base_address (base_address),
        .word_count   (word_count),
        .byte_valid   (byte_valid),
        .byte_in      (byte_in),
        .byte_ready   (byte_ready),
        .gravar_D     (gravar_D),
        .write_os     (write_os),
        .write_address(write_address),
        .data_write   (data_write),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Observe the write port and status away from the rising edge.
    always @(negedge clock) begin
        if (gravar_D) wr_log.push_back({write_os, write_address, data_write});
        if (done) done_pulses++;
        if (gravar_D && byte_ready) ready_in_write++;
    end

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_byte_ready"},    96'(byte_ready),    96'(0));
        checkOutput({tag, "_gravar_D"},      96'(gravar_D),      96'(0));
        checkOutput({tag, "_write_os"},      96'(write_os),      96'(0));
        checkOutput({tag, "_write_address"}, 96'(write_address), 96'(0));
        checkOutput({tag, "_data_write"},    96'(data_write),    96'(0));
        checkOutput({tag, "_busy"},          96'(busy),          96'(0));
        checkOutput({tag, "_done"},          96'(done),          96'(0));
        checkOutput({tag, "_error"},         96'(error),         96'(0));
    endtask

    // Run one complete load and compare everything against the model.
    task automatic applyStimulus(input bit os, input logic [31:0] base, input logic [11:0] count,
                                 input int gap, input bit mid_start, input bit csum_bad,
                                 input bit exp_range_err);
        logic [7:0]  all_b[$];
        logic [31:0] words[$];
        logic [31:0] w;
        bit          exp_err;
        bit          accepted;
        bit          tog;
        int          idx, cyc, limit, wait_cyc, base_writes, base_done, exp_writes;
`ifdef LOADER_CHECKSUM_EN
        logic [31:0] sum;
        logic [31:0] cs;
`endif
        while (byte_q.size() < 4 * int'(count)) byte_q.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < int'(count); i++) begin
            w = {byte_q[4*i], byte_q[4*i+1], byte_q[4*i+2], byte_q[4*i+3]};
            words.push_back(w);
        end
        exp_err = exp_range_err;
        if (!exp_range_err) begin
            for (int i = 0; i < 4 * int'(count); i++) all_b.push_back(byte_q[i]);
`ifdef LOADER_CHECKSUM_EN
            sum = 32'd0;
            foreach (words[i]) sum = sum + words[i];
            cs = csum_bad ? sum + 32'd1 : sum;
            all_b.push_back(cs[31:24]);
            all_b.push_back(cs[23:16]);
            all_b.push_back(cs[15:8]);
            all_b.push_back(cs[7:0]);
            if (csum_bad) exp_err = 1'b1;
`else
            if (csum_bad) $display("[TB] checksum option ignored in this build");
`endif
        end
        base_writes = wr_log.size();
        base_done   = done_pulses;

        @(posedge clock); #1;
        target_os    = os;
        base_address = base;
        word_count   = count;
        start        = 1'b1;
        @(posedge clock); #1;
        start        = 1'b0;
        target_os    = ~os;
        base_address = $urandom;
        word_count   = 12'($urandom);

        idx   = 0;
        cyc   = 0;
        tog   = 1'b1;
        limit = all_b.size() * 20 + 20;
        while (idx < all_b.size() && cyc < limit) begin
            case (gap)
                0:       byte_valid = 1'b1;
                1:       byte_valid = tog;
                default: byte_valid = 1'($urandom_range(0, 1));
            endcase
            byte_in = byte_valid ? all_b[idx] : 8'($urandom_range(0, 255));
            start   = mid_start && (cyc == 1);
            if (start) base_address = $urandom;
            @(negedge clock);
            accepted = byte_valid && byte_ready;
            @(posedge clock); #1;
            if (accepted) idx++;
            tog = ~tog;
            cyc++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        checkOutput("bytes_accepted", 96'(idx), 96'(all_b.size()));

        wait_cyc = 0;
        while (done_pulses == base_done && wait_cyc < 20) begin
            @(posedge clock); #1;
            wait_cyc++;
        end
        repeat (3) @(posedge clock);
        #1;

        exp_writes = exp_range_err ? 0 : int'(count);
        checkOutput("error", 96'(error), 96'(exp_err));
        checkOutput("done_pulses", 96'(done_pulses - base_done), 96'(1));
        if (exp_range_err) checkOutput("done_latency_ok", 96'(wait_cyc <= 2), 96'(1));
        checkOutput("write_count", 96'(wr_log.size() - base_writes), 96'(exp_writes));
        for (int i = 0; i < exp_writes && (base_writes + i) < wr_log.size(); i++) begin
            checkOutput("write_rec", 96'(wr_log[base_writes + i]),
                        96'({os, 32'(base + 32'(i)), words[i]}));
        end
        checkOutput("ready_in_write", 96'(ready_in_write), 96'(0));
        checkOutput("idle_busy", 96'(busy), 96'(0));
        checkOutput("idle_byte_ready", 96'(byte_ready), 96'(0));
        byte_q.delete();
    endtask

    // Reset asserted after two bytes of the first word must abort silently.
    task automatic resetMidLoad();
        int base_writes, base_done;
        base_writes = wr_log.size();
        base_done   = done_pulses;
        @(posedge clock); #1;
        target_os    = 1'b1;
        base_address = 32'h100;
        word_count   = 12'd2;
        start        = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            byte_valid = 1'b1;
            byte_in    = 8'hA0 + 8'(i);
            @(posedge clock); #1;
        end
        byte_valid = 1'b0;
        reset      = 1'b1;
        @(posedge clock); #1;
        checkIdleZero("mid_reset");
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            byte_valid = 1'b1;
            byte_in    = 8'(i);
            @(posedge clock); #1;
        end
        byte_valid = 1'b0;
        checkOutput("mid_reset_no_write", 96'(wr_log.size() - base_writes), 96'(0));
        checkOutput("mid_reset_no_done", 96'(done_pulses - base_done), 96'(0));
        checkOutput("mid_reset_busy", 96'(busy), 96'(0));
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        done_pulses    = 0;
        ready_in_write = 0;
        reset          = 1'b1;
        start          = 1'b0;
        target_os      = 1'b0;
        base_address   = 32'd0;
        word_count     = 12'd0;
        byte_valid     = 1'b0;
        byte_in        = 8'd0;

        vecs[0] = '{1'b1, 32'h10,       12'd2,   0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'd2047,     12'd3,   0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 32'd2046,     12'd3,   2, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'd2050,     12'd0,   0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 32'd2049,     12'd0,   0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'd0,        12'd4,   2, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'hFFFFFF00, 12'd1,   0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 32'd100,      12'd3,   1, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 32'd0,        12'hFFF, 0, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 32'd2048,     12'd1,   0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clock);
        #1;
        checkIdleZero("reset");
        reset = 1'b0;
        @(posedge clock); #1;
        checkIdleZero("post_reset");

        $display("[TB] scenario 1: kernel load of two words");
        byte_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        applyStimulus(1'b1, 32'h10, 12'd2, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] scenario 2: out-of-range load");
        applyStimulus(1'b0, 32'd2047, 12'd3, 0, 1'b0, 1'b0, 1'b1);

        $display("[TB] scenario 3: single word with gapped byte_valid");
        byte_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        applyStimulus(1'b0, 32'h40, 12'd1, 1, 1'b0, 1'b0, 1'b0);

        $display("[TB] scenario 4: reset mid-load");
        resetMidLoad();

`ifdef LOADER_CHECKSUM_EN
        $display("[TB] scenario 5: checksum good and bad");
        byte_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        applyStimulus(1'b0, 32'h20, 12'd2, 0, 1'b0, 1'b0, 1'b0);
        byte_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        applyStimulus(1'b0, 32'h20, 12'd2, 0, 1'b0, 1'b1, 1'b0);
`endif

        $display("[TB] scenario 6: empty load");
        applyStimulus(1'b0, 32'd0, 12'd0, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] table vectors");
        for (int t = 0; t < 10; t++) begin
            byte_q.delete();
            applyStimulus(vecs[t].os, vecs[t].base, vecs[t].count, vecs[t].gap,
                          vecs[t].mid_start, vecs[t].csum_bad, vecs[t].exp_range_err);
        end

        $display("[TB] randomized loads");
        for (int r = 0; r < 15; r++) begin
            logic [31:0] rb;
            logic [11:0] rc;
            rb = 32'($urandom_range(0, 2060));
            rc = 12'($urandom_range(0, 5));
            byte_q.delete();
            applyStimulus(1'($urandom_range(0, 1)), rb, rc, 2, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          ({1'b0, rb} + {21'b0, rc}) > 33'd2049);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
